// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
// Read-side consumer for a show-ahead synchronous FIFO. Narrow FIFO words are
// popped and packed PACK at a time into one wide beat, which is then offered
// downstream over a valid/ready stream. A flush request closes out a partially
// filled beat so trailing words never sit in the packer.
//
// Ports:
//   i_clk         clock, all state on the rising edge
//   i_rst         asynchronous active-high reset
//   i_fifo_data   FIFO head word, valid whenever i_fifo_empty=0
//   i_fifo_empty  FIFO empty flag
//   o_fifo_rd_en  pop request; the FIFO advances at an edge where this is 1
//   i_flush       single-cycle request to emit the current partial beat
//   o_data        packed beat, word k at [k*WIDTH +: WIDTH], first word at LSB
//   o_words       number of valid words in o_data (1..PACK while o_valid=1)
//   o_valid       beat valid
//   i_ready       downstream accepts the beat when o_valid=1
module fifo_rd_packer #(
  parameter int WIDTH    = 4,
  parameter int PACK     = 4,
  parameter int PACK_LEN = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [WIDTH-1:0]        i_fifo_data,
  input  logic                    i_fifo_empty,
  output logic                    o_fifo_rd_en,
  input  logic                    i_flush,
  output logic [WIDTH*PACK-1:0]   o_data,
  output logic [PACK_LEN:0]       o_words,
  output logic                    o_valid,
  input  logic                    i_ready
);

  typedef enum logic {
    S_FILL,
    S_HOLD
  } state_t;

  localparam logic [PACK_LEN:0] LP_ONE  = (PACK_LEN+1)'(1);
  localparam logic [PACK_LEN:0] LP_LAST = (PACK_LEN+1)'(PACK - 1);
  localparam logic [PACK_LEN:0] LP_FULL = (PACK_LEN+1)'(PACK);

  state_t                  r_state;
  logic [PACK_LEN:0]       r_count;
  logic [PACK_LEN:0]       r_words;
  logic [WIDTH*PACK-1:0]   r_data;
  logic                    r_valid;

  logic                    w_pop;
  logic [PACK_LEN-1:0]     w_lane;

  // A held beat only makes room for a new word on the edge it is accepted,
  // so popping in HOLD is gated by i_ready; the word then lands in lane 0.
  assign w_pop  = !i_rst && !i_fifo_empty &&
                  ((r_state == S_FILL) || ((r_state == S_HOLD) && i_ready));
  assign w_lane = r_count[PACK_LEN-1:0];

  assign o_fifo_rd_en = w_pop;
  assign o_data       = r_data;
  assign o_words      = r_words;
  assign o_valid      = r_valid;

  // Packer FSM. The lanes double as the output register: they are cleared on
  // every handshake, so lanes left unfilled by a flushed beat read as zero.
  // In FILL, count is always below PACK, so its low bits index the next lane.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_FILL;
      r_count <= '0;
      r_words <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_pop) begin
            r_data[w_lane*WIDTH +: WIDTH] <= i_fifo_data;
            r_count <= r_count + LP_ONE;
            // The last pop and a flush with a same-cycle pop both close the
            // beat including this word; with count at PACK-1 that is PACK.
            if ((r_count == LP_LAST) || i_flush) begin
              r_state <= S_HOLD;
              r_valid <= 1'b1;
              r_words <= r_count + LP_ONE;
            end
          end else if (i_flush && (r_count != '0)) begin
            r_state <= S_HOLD;
            r_valid <= 1'b1;
            r_words <= r_count;
          end
        end
        S_HOLD: begin
          if (i_ready) begin
            r_state <= S_FILL;
            r_valid <= 1'b0;
            r_words <= '0;
            r_data  <= '0;
            r_count <= '0;
            if (w_pop) begin
              r_data[WIDTH-1:0] <= i_fifo_data;
              r_count <= LP_ONE;
            end
          end
        end
        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

  // Interface and internal invariants.
  a_no_pop_empty: assert property (@(posedge i_clk) disable iff (i_rst)
    o_fifo_rd_en |-> !i_fifo_empty);

  a_hold_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_valid && !i_ready) |=> ($stable(o_data) && $stable(o_words)));

  a_words_nonzero: assert property (@(posedge i_clk) disable iff (i_rst)
    o_valid |-> (o_words != '0));

  a_count_bound: assert property (@(posedge i_clk) disable iff (i_rst)
    r_count <= LP_FULL);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer
// Self-checking bench for fifo_rd_packer. The bench plays the FIFO (a queue of
// words) and keeps a queue-based reference of the packer: popped words gather
// in a list, and a beat is formed when the list reaches PACK words or a flush
// arrives while filling. Outputs are compared every cycle at the falling edge.
module tb_fifo_rd_packer;

  localparam int W  = 4;
  localparam int P  = 4;
  localparam int PL = 2;

  logic              i_clk;
  logic              i_rst;
  logic [W-1:0]      i_fifo_data;
  logic              i_fifo_empty;
  logic              o_fifo_rd_en;
  logic              i_flush;
  logic [W*P-1:0]    o_data;
  logic [PL:0]       o_words;
  logic              o_valid;
  logic              i_ready;

  int checks;
  int failures;

  // FIFO side
  logic [W-1:0] srcQ[$];
  bit           gateEmpty;

  // Reference model of the packer
  logic [W-1:0] mAcc[$];
  bit           mValid;
  logic [W*P-1:0] mData;
  int           mWords;
  bit           expRdEn;

  // Beats accepted by downstream, captured as {words, data}
  logic [PL+W*P:0] capQ[$];
  int rdCount;

  fifo_rd_packer #(.WIDTH(W), .PACK(P), .PACK_LEN(PL)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_fifo_data(i_fifo_data),
    .i_fifo_empty(i_fifo_empty),
    .o_fifo_rd_en(o_fifo_rd_en),
    .i_flush(i_flush),
    .o_data(o_data),
    .o_words(o_words),
    .o_valid(o_valid),
    .i_ready(i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Single comparison point: every check goes through here.
  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refreshFifo();
    i_fifo_empty = (srcQ.size() == 0) || gateEmpty;
    i_fifo_data  = (srcQ.size() != 0) ? srcQ[0] : '0;
  endtask

  task automatic modelReset();
    mAcc.delete();
    mValid = 1'b0;
    mData  = '0;
    mWords = 0;
  endtask

  // Advance the reference by one clock edge using the current inputs.
  task automatic modelStep(input bit pop, input logic [W-1:0] word, input bit flush, input bit ready);
    bit wasFill;
    wasFill = !mValid;
    if (mValid && ready) mValid = 1'b0;
    if (pop) mAcc.push_back(word);
    if (wasFill && ((mAcc.size() == P) || (flush && (mAcc.size() > 0)))) begin
      mData = '0;
      foreach (mAcc[k]) mData[k*W +: W] = mAcc[k];
      mWords = mAcc.size();
      mAcc.delete();
      mValid = 1'b1;
    end
  endtask

  task automatic checkOutput();
    expRdEn = !i_fifo_empty && (!mValid || i_ready);
    compare("rd_en", 64'(o_fifo_rd_en), 64'(expRdEn));
    compare("valid", 64'(o_valid), 64'(mValid));
    if (mValid) begin
      compare("data", 64'(o_data), 64'(mData));
      compare("words", 64'(o_words), 64'(mWords));
    end
    if (o_fifo_rd_en) rdCount++;
    if (o_valid && i_ready) capQ.push_back({o_words, o_data});
  endtask

  // One clock cycle: inputs are applied just after a rising edge, outputs
  // are checked at the falling edge, then the model and FIFO advance.
  task automatic applyStimulus(input bit rdy, input bit fl, input bit gt);
    i_ready   = rdy;
    i_flush   = fl;
    gateEmpty = gt;
    refreshFifo();
    @(negedge i_clk);
    checkOutput();
    modelStep(expRdEn, i_fifo_data, i_flush, i_ready);
    if (o_fifo_rd_en && (srcQ.size() != 0)) void'(srcQ.pop_front());
    @(posedge i_clk);
    #1;
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic doReset();
    i_flush = 1'b0;
    i_rst   = 1'b1;
    #2;
    compare("rst_valid", 64'(o_valid), 64'd0);
    compare("rst_data", 64'(o_data), 64'd0);
    compare("rst_words", 64'(o_words), 64'd0);
    compare("rst_rd_en", 64'(o_fifo_rd_en), 64'd0);
    modelReset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic startTest();
    doReset();
    srcQ.delete();
    capQ.delete();
    rdCount = 0;
  endtask

  initial begin
    logic [W-1:0] sent[$];
    logic [W-1:0] got[$];
    logic [PL+W*P:0] beat;
    int nw;

    checks    = 0;
    failures  = 0;
    i_rst     = 1'b0;
    i_ready   = 1'b0;
    i_flush   = 1'b0;
    gateEmpty = 1'b0;
    refreshFifo();
    modelReset();
    #3;

    // 1: steady stream of 8 words with ready held high
    startTest();
    for (int v = 1; v <= 8; v++) srcQ.push_back(W'(v));
    for (int t = 0; t < 8; t++) applyStimulus(1'b1, 1'b0, 1'b0);
    compare("t1_pops", 64'(rdCount), 64'd8);
    for (int t = 0; t < 2; t++) applyStimulus(1'b1, 1'b0, 1'b0);
    compare("t1_nbeats", 64'(capQ.size()), 64'd2);
    if (capQ.size() == 2) begin
      compare("t1_beat0", 64'(capQ[0]), 64'({3'd4, 16'h4321}));
      compare("t1_beat1", 64'(capQ[1]), 64'({3'd4, 16'h8765}));
    end

    // 2: backpressure for 5 cycles after the first beat appears
    startTest();
    for (int v = 1; v <= 8; v++) srcQ.push_back(W'(v));
    for (int t = 0; t < 15; t++) begin
      applyStimulus((t >= 4 && t <= 8) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      if (t == 8) compare("t2_pops_held", 64'(rdCount), 64'd4);
    end
    compare("t2_nbeats", 64'(capQ.size()), 64'd2);
    if (capQ.size() == 2) begin
      compare("t2_beat0", 64'(capQ[0]), 64'({3'd4, 16'h4321}));
      compare("t2_beat1", 64'(capQ[1]), 64'({3'd4, 16'h8765}));
    end

    // 3: sparse FIFO, empty every other cycle, random backpressure
    startTest();
    sent.delete();
    for (int v = 0; v < 12; v++) begin
      sent.push_back(W'($urandom));
      srcQ.push_back(sent[v]);
    end
    for (int t = 0; t < 60; t++) applyStimulus(($urandom_range(0, 9) < 7), 1'b0, t[0]);
    for (int t = 0; t < 4; t++) applyStimulus(1'b1, 1'b0, 1'b0);
    got.delete();
    foreach (capQ[b]) begin
      beat = capQ[b];
      nw   = int'(beat[PL+W*P:W*P]);
      for (int k = 0; k < nw && k < P; k++) got.push_back(beat[k*W +: W]);
    end
    compare("t3_nwords", 64'(got.size()), 64'd12);
    if (got.size() == 12)
      foreach (sent[i]) compare("t3_order", 64'(got[i]), 64'(sent[i]));

    // 4: flush a partial beat of three words
    startTest();
    srcQ.push_back(4'hA);
    srcQ.push_back(4'hB);
    srcQ.push_back(4'hC);
    for (int t = 0; t < 3; t++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    compare("t4_nbeats", 64'(capQ.size()), 64'd1);
    if (capQ.size() == 1) compare("t4_beat", 64'(capQ[0]), 64'({3'd3, 16'h0CBA}));

    // 5a: flush with nothing accumulated is ignored
    startTest();
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    compare("t5a_valid", 64'(o_valid), 64'd0);
    compare("t5a_nbeats", 64'(capQ.size()), 64'd0);

    // 5b: flush coinciding with the PACK-th pop gives a full beat
    startTest();
    for (int v = 1; v <= 4; v++) srcQ.push_back(W'(v));
    for (int t = 0; t < 3; t++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    compare("t5b_nbeats", 64'(capQ.size()), 64'd1);
    if (capQ.size() == 1) compare("t5b_beat", 64'(capQ[0]), 64'({3'd4, 16'h4321}));

    // 6: reset mid-beat discards the partial beat
    startTest();
    srcQ.push_back(4'h1);
    srcQ.push_back(4'h2);
    for (int t = 0; t < 2; t++) applyStimulus(1'b1, 1'b0, 1'b0);
    startTest();
    for (int v = 5; v <= 8; v++) srcQ.push_back(W'(v));
    for (int t = 0; t < 6; t++) applyStimulus(1'b1, 1'b0, 1'b0);
    compare("t6_nbeats", 64'(capQ.size()), 64'd1);
    if (capQ.size() == 1) compare("t6_beat", 64'(capQ[0]), 64'({3'd4, 16'h8765}));

    // Random soak: random arrivals, gaps, backpressure, flushes and resets
    startTest();
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end else begin
        if ((srcQ.size() < 6) && $urandom_range(0, 1)) srcQ.push_back(W'($urandom));
        applyStimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 9) < 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
